// File: rtl/rlwe_sched_pkg.sv
// Shared definitions for the add/conv job scheduler: FSM encoding, op codes,
// default watchdog limit and the default-width command record.
package rlwe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_CONV = 1'b1;

    localparam int TIMEOUT_DEF = 4096;
    localparam int TAG_W_DEF   = 4;

    // Queue entries are packed op-over-tag, matching this record layout.
    typedef struct packed {
        logic                 op;
        logic [TAG_W_DEF-1:0] tag;
    } sched_cmd_t;

endpackage

// File: rtl/rlwe_sched_cmd_fifo.sv
// Small synchronous command queue; pointers carry one extra wrap bit so
// full and empty can be told apart without a separate occupancy counter.
module rlwe_sched_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rlwe_processor_add_conv_scheduler.sv
// Queues add/conv jobs, runs both control cores in lock-step per job under a
// watchdog, and returns a tagged response to the instruction controller.
//
// state | meaning
// IDLE  | cores held in reset; pop next queued job if any
// LOAD  | cores in reset, add_conv stable for LOAD_CYCLES cycles
// RUN   | cores released; collect done pulses, watchdog counting
// RESP  | cores in reset; response held until rsp_ready
module rlwe_processor_add_conv_scheduler
    import rlwe_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             core_rst,
    output logic             add_conv,
    input  logic [1:0]       core_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_op,
    output logic             rsp_err,
    output logic [1:0]       rsp_core_mask,
    output logic             busy,
    output logic [15:0]      job_count
);
    localparam int CW   = 1 + TAG_W;
    localparam int WD_W = $clog2(TIMEOUT);
    localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    sched_state_t     state_q, state_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_dout;
    logic [LC_W-1:0]  load_cnt_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic [1:0]       done_seen_q, done_set;
    logic [TAG_W-1:0] job_tag_q;
    logic             complete, timed_out, rsp_fire;

    logic             core_rst_d, add_conv_d, rsp_valid_d, rsp_op_d, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_d;
    logic [1:0]       rsp_mask_d;
    logic [15:0]      job_count_d;

    rlwe_sched_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({cmd_op, cmd_tag}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    // Pulses landing this cycle count toward completion immediately.
    assign done_set  = done_seen_q | core_done;
    assign complete  = (done_set == 2'b11);
    assign timed_out = (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign rsp_fire  = (state_q == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fifo_pop) state_d = ST_LOAD;
            ST_LOAD: if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) state_d = ST_RUN;
            ST_RUN:  if (complete || timed_out) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_rst_d  = (state_d != ST_RUN);
        add_conv_d  = fifo_pop ? fifo_dout[CW-1] : add_conv;
        rsp_valid_d = rsp_valid;
        rsp_tag_d   = rsp_tag;
        rsp_op_d    = rsp_op;
        rsp_err_d   = rsp_err;
        rsp_mask_d  = rsp_core_mask;
        job_count_d = job_count;
        if (state_q == ST_RUN && state_d == ST_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = job_tag_q;
            rsp_op_d    = add_conv;
            rsp_err_d   = !complete;
            rsp_mask_d  = done_set;
        end
        if (rsp_fire) begin
            rsp_valid_d = 1'b0;
            if (!rsp_err)
                job_count_d = job_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst      <= 1'b1;
            add_conv      <= OP_ADD;
            rsp_valid     <= 1'b0;
            rsp_tag       <= '0;
            rsp_op        <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_core_mask <= 2'b00;
            job_count     <= 16'd0;
        end else begin
            core_rst      <= core_rst_d;
            add_conv      <= add_conv_d;
            rsp_valid     <= rsp_valid_d;
            rsp_tag       <= rsp_tag_d;
            rsp_op        <= rsp_op_d;
            rsp_err       <= rsp_err_d;
            rsp_core_mask <= rsp_mask_d;
            job_count     <= job_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q  <= '0;
            wd_cnt_q    <= '0;
            done_seen_q <= 2'b00;
            job_tag_q   <= '0;
        end else begin
            load_cnt_q <= (state_q == ST_LOAD) ? load_cnt_q + 1'b1 : '0;
            wd_cnt_q   <= (state_q == ST_RUN)  ? wd_cnt_q + 1'b1   : '0;
            if (fifo_pop) begin
                done_seen_q <= 2'b00;
                job_tag_q   <= fifo_dout[TAG_W-1:0];
            end else if (state_q == ST_RUN) begin
                done_seen_q <= done_set;
            end
        end
    end

endmodule

// File: tb/tb_rlwe_processor_add_conv_scheduler.sv
// Directed bench for the add/conv scheduler: latency, skewed and simultaneous
// dones, queue back-pressure, watchdog timeout, response hold and mid-job reset.
module tb_rlwe_processor_add_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [3:0] cmd_tag = 4'd0;
    logic       core_rst;
    logic       add_conv;
    logic [1:0] core_done = 2'b00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_tag;
    logic       rsp_op;
    logic       rsp_err;
    logic [1:0] rsp_core_mask;
    logic       busy;
    logic [15:0] job_count;

    int n_tests = 0;
    int n_fail  = 0;

    rlwe_processor_add_conv_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_tag       (cmd_tag),
        .core_rst      (core_rst),
        .add_conv      (add_conv),
        .core_done     (core_done),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tag       (rsp_tag),
        .rsp_op        (rsp_op),
        .rsp_err       (rsp_err),
        .rsp_core_mask (rsp_core_mask),
        .busy          (busy),
        .job_count     (job_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic op, input logic [3:0] tag);
        int w;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_tag   = tag;
        w = 0;
        while (!cmd_ready && w < 100) begin
            tick();
            w++;
        end
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns the number of cycles core_rst was still high, stopping at RUN cycle 0.
    task automatic wait_release(output int n);
        n = 0;
        while (core_rst && n < 40) begin
            tick();
            n++;
        end
        check("release_seen", core_rst, 0);
    endtask

    // Called at RUN cycle 0; pulses core_done[0] at k0, core_done[1] at k1.
    task automatic drive_dones(input int k0, input int k1);
        int  last;
        logic early;
        last  = (k0 > k1) ? k0 : k1;
        early = 1'b0;
        for (int c = 0; c <= last; c++) begin
            core_done = {(c == k1), (c == k0)};
            if (rsp_valid) early = 1'b1;
            tick();
        end
        core_done = 2'b00;
        check("no_early_rsp", early, 0);
        check("rsp_next_cycle", rsp_valid, 1);
    endtask

    initial begin
        int   n;
        logic moved;
        logic [4:0] ops;

        #1 rst = 1'b0;
        tick();
        tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_add_conv", add_conv, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_job_count", job_count, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b1;
        tick();

        // Single add, exact release latency, response held until ready
        push(1'b0, 4'd5);
        check("lat_busy", busy, 1);
        check("lat_t1_core_rst", core_rst, 1);
        tick();
        check("lat_load1_core_rst", core_rst, 1);
        tick();
        check("lat_load2_core_rst", core_rst, 1);
        tick();
        check("lat_release", core_rst, 0);
        drive_dones(2060, 2060);
        check("add_tag", rsp_tag, 5);
        check("add_op", rsp_op, 0);
        check("add_err", rsp_err, 0);
        check("add_mask", rsp_core_mask, 2'b11);
        check("add_core_rst_resp", core_rst, 1);
        check("add_cnt_before_ack", job_count, 0);
        rsp_ready = 1'b1;
        tick();
        check("add_rsp_cleared", rsp_valid, 0);
        check("add_job_count", job_count, 1);

        // Skewed dones, then simultaneous dones
        push(1'b1, 4'd7);
        wait_release(n);
        check("skew_add_conv", add_conv, 1);
        drive_dones(100, 300);
        check("skew_tag", rsp_tag, 7);
        check("skew_op", rsp_op, 1);
        check("skew_mask", rsp_core_mask, 2'b11);
        check("skew_err", rsp_err, 0);
        tick();
        push(1'b0, 4'd8);
        wait_release(n);
        check("same_add_conv", add_conv, 0);
        drive_dones(50, 50);
        check("same_tag", rsp_tag, 8);
        tick();
        check("same_job_count", job_count, 3);

        // Timeout with only core 0 reporting
        push(1'b0, 4'd9);
        wait_release(n);
        moved = 1'b0;
        for (int c = 0; c < 4096; c++) begin
            core_done = {1'b0, (c == 10)};
            if (rsp_valid) moved = 1'b1;
            tick();
        end
        core_done = 2'b00;
        check("to_no_early", moved, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_mask", rsp_core_mask, 2'b01);
        check("to_tag", rsp_tag, 9);
        tick();
        check("to_job_count", job_count, 3);

        // Last done on the timeout cycle: completion wins
        push(1'b1, 4'd10);
        wait_release(n);
        drive_dones(10, 4095);
        check("tie_err", rsp_err, 0);
        check("tie_mask", rsp_core_mask, 2'b11);
        tick();
        check("tie_job_count", job_count, 4);

        // Back-to-back: five commands, queue fills at four
        ops = 5'b01101;
        for (int i = 0; i < 5; i++)
            push(ops[i], 4'(i + 1));
        check("b2b_full", cmd_ready, 0);
        for (int i = 0; i < 5; i++) begin
            wait_release(n);
            if (i > 0) check("b2b_load_phase", n, 4);
            check("b2b_add_conv", add_conv, ops[i]);
            drive_dones(3 * i + 2, 5);
            check("b2b_tag", rsp_tag, i + 1);
            check("b2b_op", rsp_op, ops[i]);
        end
        tick();
        check("b2b_idle", busy, 0);
        check("b2b_job_count", job_count, 9);

        // Backpressure: response held, queued job must not start
        rsp_ready = 1'b0;
        push(1'b1, 4'd12);
        wait_release(n);
        drive_dones(5, 5);
        push(1'b0, 4'd13);
        moved = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd12 || rsp_op !== 1'b1 ||
                rsp_err !== 1'b0 || rsp_core_mask !== 2'b11 || core_rst !== 1'b1 ||
                add_conv !== 1'b1)
                moved = 1'b1;
            tick();
        end
        check("bp_stable", moved, 0);
        check("bp_busy", busy, 1);
        rsp_ready = 1'b1;
        tick();
        check("bp_job_count", job_count, 10);
        wait_release(n);
        check("bp_next_add_conv", add_conv, 0);
        push(1'b1, 4'd14);
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_core_rst", core_rst, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_job_count", job_count, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_tag", rsp_tag, 0);
        tick();
        rst = 1'b1;
        moved = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid || busy || !core_rst) moved = 1'b1;
            tick();
        end
        check("post_rst_quiet", moved, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
